// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Central stall/flush sequencer for a 5-stage MIPS pipeline. Merges the
//   ID-stage hazard flag, the EXE-stage branch-taken flag and the MEM-stage
//   SRAM handshake into freeze/bubble/flush controls, watches multi-cycle SRAM
//   waits with a watchdog, and keeps saturating stall/flush counters.
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   hazard_det      ID instruction must stall
//   branch_taken    EXE-stage branch/jump resolved taken
//   mem_r_en/w_en   MEM stage read/write request
//   sram_ready      SRAM done this cycle (only meaningful with a request)
//   freeze_pc       hold PC
//   freeze_if_id    hold IF/ID
//   bubble_id_ex    load NOP into ID/EX
//   flush_if_id     clear IF/ID to NOP
//   freeze_back     hold ID/EX, EX/MEM and MEM/WB
//   ctrl_state      00 RUN, 01 MEM_WAIT, 10 ERROR
//   wd_error        sticky watchdog error
//   stall_cycles    saturating count of cycles with freeze_pc=1
//   flush_count     saturating count of cycles with flush_if_id=1
module pipeline_stall_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WD_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_det,
  input  logic             branch_taken,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             freeze_back,
  output logic [1:0]       ctrl_state,
  output logic             wd_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_ERROR    = 2'b10;

  localparam int unsigned    WC_W    = $clog2(WD_LIMIT + 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(WD_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]      state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            wd_error_q, wd_error_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic mem_req, mem_stall;
  // Branch wins over hazard: the stalled ID instruction is flushed anyway.
  logic hz_stall;

  assign mem_req   = mem_r_en | mem_w_en;
  assign mem_stall = mem_req & ~sram_ready;
  assign hz_stall  = hazard_det & ~branch_taken;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    wd_error_d   = wd_error_q;
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    freeze_back  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          freeze_pc    = 1'b1;
          freeze_if_id = 1'b1;
          freeze_back  = 1'b1;
          state_d      = ST_MEM_WAIT;
          wait_cnt_d   = WC_W'(1);
        end else begin
          freeze_pc    = hz_stall;
          freeze_if_id = hz_stall;
          bubble_id_ex = branch_taken | hazard_det;
          flush_if_id  = branch_taken;
        end
      end
      ST_MEM_WAIT: begin
        // A dropped request releases the wait just like sram_ready.
        if (!mem_req || sram_ready) begin
          freeze_pc    = hz_stall;
          freeze_if_id = hz_stall;
          bubble_id_ex = branch_taken | hazard_det;
          flush_if_id  = branch_taken;
          state_d      = ST_RUN;
          wait_cnt_d   = '0;
        end else begin
          freeze_pc    = 1'b1;
          freeze_if_id = 1'b1;
          freeze_back  = 1'b1;
          if (wait_cnt_q < WC_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end else begin
            state_d    = ST_ERROR;
            wd_error_d = 1'b1;
          end
        end
      end
      default: begin
        // ERROR (and the unused encoding) holds everything until reset.
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        freeze_back  = 1'b1;
        state_d      = ST_ERROR;
      end
    endcase

    if (rst) begin
      freeze_pc    = 1'b0;
      freeze_if_id = 1'b0;
      bubble_id_ex = 1'b0;
      flush_if_id  = 1'b0;
      freeze_back  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      wd_error_q <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wd_error_q <= wd_error_d;
      if (freeze_pc && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush_if_id && (flush_q != CNT_MAX)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign ctrl_state   = state_q;
  assign wd_error     = wd_error_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule
